// File: rtl/commit_trace_monitor.sv
// commit_trace_monitor
//    Snoops register-file writeback, data-memory stores and the fetch PC of
//    the pipeline core. Every cycle with a qualifying event queues one
//    time-stamped commit record in a DEPTH-entry FIFO, drained over a
//    valid/ready port. A PC that stays unchanged for HALT_CYCLES consecutive
//    comparisons declares program end and freezes capture and the cycle count.
//
// Ports
//    clk, rst_n        clock (rising edge), asynchronous active-low reset
//    clr               synchronous clear of FIFO, counters and flags
//    pc_in             current fetch PC
//    reg_we/rd/wdata   register-file writeback snoop
//    mem_we/addr/wdata DMEM store snoop
//    trace_*           head record of the FIFO, valid/ready handshake
//    fill              records queued
//    overflow          sticky, a record was dropped on a full FIFO
//    drop_count        dropped records, saturating
//    halted            sticky program-end flag
//    cycle_count       cycle counter, frozen once halted
module commit_trace_monitor #(
   parameter int XLEN        = 32,
   parameter int DEPTH       = 16,
   parameter int HALT_CYCLES = 4,
   parameter int CNT_W       = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic [XLEN-1:0]            pc_in,
   input  logic                       reg_we,
   input  logic [4:0]                 reg_rd,
   input  logic [XLEN-1:0]            reg_wdata,
   input  logic                       mem_we,
   input  logic [XLEN-1:0]            mem_addr,
   input  logic [XLEN-1:0]            mem_wdata,
   output logic                       trace_valid,
   input  logic                       trace_ready,
   output logic                       trace_reg_v,
   output logic [4:0]                 trace_rd,
   output logic [XLEN-1:0]            trace_reg_data,
   output logic                       trace_mem_v,
   output logic [XLEN-1:0]            trace_mem_addr,
   output logic [XLEN-1:0]            trace_mem_data,
   output logic [CNT_W-1:0]           trace_cycle,
   output logic [$clog2(DEPTH):0]     fill,
   output logic                       overflow,
   output logic [15:0]                drop_count,
   output logic                       halted,
   output logic [CNT_W-1:0]           cycle_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = AW + 1;
   localparam int HW = $clog2(HALT_CYCLES + 1);

   typedef struct packed {
      logic             reg_v;
      logic [4:0]       rd;
      logic [XLEN-1:0]  reg_data;
      logic             mem_v;
      logic [XLEN-1:0]  mem_addr;
      logic [XLEN-1:0]  mem_data;
      logic [CNT_W-1:0] cycle;
   } rec_t;

   rec_t             rec_mem [DEPTH];
   rec_t             new_rec;
   rec_t             head;

   logic [AW-1:0]    rptr;
   logic [AW-1:0]    wptr;
   logic [FW-1:0]    fill_q;
   logic             overflow_q;
   logic [15:0]      drop_q;
   logic             halted_q;
   logic [CNT_W-1:0] cycle_q;

   logic [XLEN-1:0]  prev_pc;
   logic             prev_ok;
   logic [HW-1:0]    stable;

   logic             reg_ev;
   logic             mem_ev;
   logic             push;
   logic             pop;
   logic             full;
   logic             accept;
   logic             drop;
   logic             pc_same;

   assign reg_ev  = reg_we && (reg_rd != 5'd0);
   assign mem_ev  = mem_we;
   assign push    = (reg_ev || mem_ev) && !halted_q;
   assign full    = (fill_q == FW'(DEPTH));
   assign pop     = trace_valid && trace_ready;
   // A full FIFO still takes the new record when the head leaves this cycle.
   assign accept  = push && (!full || pop);
   assign drop    = push && full && !pop;
   assign pc_same = prev_ok && (pc_in == prev_pc);

   // Unqualified fields are stored as zero so the head never shows stale data.
   always_comb begin
      new_rec          = '0;
      new_rec.reg_v    = reg_ev;
      new_rec.rd       = reg_ev ? reg_rd : 5'd0;
      new_rec.reg_data = reg_ev ? reg_wdata : '0;
      new_rec.mem_v    = mem_ev;
      new_rec.mem_addr = mem_ev ? mem_addr : '0;
      new_rec.mem_data = mem_ev ? mem_wdata : '0;
      new_rec.cycle    = cycle_q;
   end

   // Storage is not reset; the head outputs are gated by trace_valid instead.
   always_ff @(posedge clk) begin
      if (accept && !clr) begin
         rec_mem[wptr] <= new_rec;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rptr       <= '0;
         wptr       <= '0;
         fill_q     <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else if (clr) begin
         rptr       <= '0;
         wptr       <= '0;
         fill_q     <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         if (accept) begin
            wptr <= wptr + 1'b1;
         end
         if (pop) begin
            rptr <= rptr + 1'b1;
         end
         case ({accept, pop})
            2'b10:   fill_q <= fill_q + 1'b1;
            2'b01:   fill_q <= fill_q - 1'b1;
            default: fill_q <= fill_q;
         endcase
         if (drop) begin
            overflow_q <= 1'b1;
            if (drop_q != 16'hFFFF) begin
               drop_q <= drop_q + 16'd1;
            end
         end
      end
   end

   // Halt detector and cycle counter. The push in the halting cycle uses the
   // old halted value, so that event is still captured.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_pc  <= '0;
         prev_ok  <= 1'b0;
         stable   <= '0;
         halted_q <= 1'b0;
         cycle_q  <= '0;
      end else if (clr) begin
         prev_pc  <= '0;
         prev_ok  <= 1'b0;
         stable   <= '0;
         halted_q <= 1'b0;
         cycle_q  <= '0;
      end else begin
         prev_pc <= pc_in;
         prev_ok <= 1'b1;
         if (pc_same) begin
            if (stable != HW'(HALT_CYCLES)) begin
               stable <= stable + 1'b1;
            end
            if (stable == HW'(HALT_CYCLES - 1)) begin
               halted_q <= 1'b1;
            end
         end else begin
            stable <= '0;
         end
         if (!halted_q) begin
            cycle_q <= cycle_q + 1'b1;
         end
      end
   end

   assign head           = rec_mem[rptr];
   assign trace_valid    = (fill_q != '0);
   assign trace_reg_v    = trace_valid && head.reg_v;
   assign trace_rd       = trace_valid ? head.rd       : 5'd0;
   assign trace_reg_data = trace_valid ? head.reg_data : '0;
   assign trace_mem_v    = trace_valid && head.mem_v;
   assign trace_mem_addr = trace_valid ? head.mem_addr : '0;
   assign trace_mem_data = trace_valid ? head.mem_data : '0;
   assign trace_cycle    = trace_valid ? head.cycle    : '0;

   assign fill        = fill_q;
   assign overflow    = overflow_q;
   assign drop_count  = drop_q;
   assign halted      = halted_q;
   assign cycle_count = cycle_q;

endmodule
